uart_cmd_monitor: RTL and testbench

UART_CMD_MONITOR -- requirements
Module: uart_cmd_monitor

---
 rtl/uart_cmd_monitor_pkg.sv | 66 ++++++
 rtl/uart_cmd_monitor_if.sv | 29 ++
 rtl/uart_cmd_monitor_hex_word_ser.sv | 61 ++++++
 rtl/uart_cmd_monitor.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_uart_cmd_monitor.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_monitor_pkg.sv
// rtl/uart_cmd_monitor_pkg.sv - state encodings, ASCII constants, prompt/error tables and hex helpers
// Purpose: shared definitions for uart_cmd_monitor and hex_word_ser.
// Ports: none (package).
package uart_cmd_monitor_pkg;

    typedef enum logic [2:0] {
        ST_PROMPT    = 3'd0,
        ST_RX_WAIT   = 3'd1,
        ST_ECHO      = 3'd2,
        ST_EXEC_W    = 3'd3,
        ST_EXEC_R    = 3'd4,
        ST_READ_WAIT = 3'd5,
        ST_RESP      = 3'd6,
        ST_ERR       = 3'd7
    } state_t;

    localparam logic [7:0] ASCII_CR    = 8'h0d;
    localparam logic [7:0] ASCII_LF    = 8'h0a;
    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_COLON = 8'h3a;

    localparam logic [2:0] PROMPT_LAST  = 3'd6;
    localparam logic [2:0] ERR_LAST     = 3'd4;
    localparam logic [5:0] MAX_LINE_LEN = 6'd32;

    // "\r\n151> "
    function automatic logic [7:0] prompt_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h0d;
            3'd1:    return 8'h0a;
            3'd2:    return 8'h31;
            3'd3:    return 8'h35;
            3'd4:    return 8'h31;
            3'd5:    return 8'h3e;
            default: return 8'h20;
        endcase
    endfunction

    // "\nERR\r"
    function automatic logic [7:0] err_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h0a;
            3'd1:    return 8'h45;
            3'd2:    return 8'h52;
            3'd3:    return 8'h52;
            default: return 8'h0d;
        endcase
    endfunction

    function automatic logic [7:0] nib_to_hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    // Returns {valid, nibble}; accepts 0-9, a-f, A-F.
    function automatic logic [4:0] hex_to_nib(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if ((c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46)) begin
            r = {1'b1, c[3:0] + 4'd9};
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_cmd_monitor_if.sv
// rtl/uart_cmd_monitor_if.sv - rx/tx byte streams, memory strobe bus and busy flag
// Purpose: bundles the monitor's handshake and memory signals.
// Modports:
//   master - the monitor: consumes rx, produces tx, drives the memory bus
//   slave  - the environment: produces rx, consumes tx, answers memory reads
interface uart_cmd_monitor_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        busy;

    modport master (
        input  rx_data, rx_valid, tx_ready, mem_rdata,
        output rx_ready, tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_re, busy
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, mem_rdata,
        input  rx_ready, tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_re, busy
    );
endinterface

// File: rtl/uart_cmd_monitor_hex_word_ser.sv
// rtl/uart_cmd_monitor_hex_word_ser.sv - serializes a 32-bit word as 8 lowercase ASCII hex digits
// Purpose: on i_start, emits the word MSB nibble first over a valid/ready byte stream,
//          then pulses o_done for one cycle after the last digit is accepted.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   i_start   - load i_word and begin (ignored mid-word by construction of the caller)
//   i_word    - word to print
//   o_tdata   - ASCII digit, stable while o_tvalid && !i_tready
//   o_tvalid  - digit valid
//   i_tready  - downstream accepts the digit
//   o_done    - one-cycle pulse after the 8th digit is accepted
module hex_word_ser
    import uart_cmd_monitor_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [31:0] i_word,
    output logic [7:0]  o_tdata,
    output logic        o_tvalid,
    input  logic        i_tready,
    output logic        o_done
);
    logic [31:0] r_word;
    logic [2:0]  r_cnt;
    logic [7:0]  r_tdata;
    logic        r_tvalid;
    logic        r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word   <= 32'd0;
            r_cnt    <= 3'd0;
            r_tdata  <= 8'd0;
            r_tvalid <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_word   <= i_word;
                r_cnt    <= 3'd0;
                r_tvalid <= 1'b1;
                r_tdata  <= nib_to_hex(i_word[31:28]);
            end else if (r_tvalid && i_tready) begin
                if (r_cnt == 3'd7) begin
                    r_tvalid <= 1'b0;
                    r_done   <= 1'b1;
                end else begin
                    // r_word[31:28] is the digit on the wire; the next one sits below it.
                    r_word  <= {r_word[27:0], 4'h0};
                    r_cnt   <= r_cnt + 3'd1;
                    r_tdata <= nib_to_hex(r_word[27:24]);
                end
            end
        end
    end

    assign o_tdata  = r_tdata;
    assign o_tvalid = r_tvalid;
    assign o_done   = r_done;
endmodule

// File: rtl/uart_cmd_monitor.sv
// rtl/uart_cmd_monitor.sv - line-oriented "sw D A" / "lw A" memory monitor over a UART byte stream
// Purpose: prints a prompt, echoes each received byte, parses the line on CR and performs
//          one word write or read, answering with "\n", "\nAAAAAAAA:DDDDDDDD\r" or "\nERR\r".
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset
//   io_bus  - uart_cmd_monitor_if.master: rx/tx streams, memory bus, busy
// Parameters:
//   PROMPT_EN - 1: prompt after reset and after every command; 0: no prompt
module uart_cmd_monitor
    import uart_cmd_monitor_pkg::*;
#(
    parameter bit PROMPT_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    uart_cmd_monitor_if.master io_bus
);
    state_t      r_state;
    logic [2:0]  r_idx;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic [7:0]  r_rx_byte;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_we;
    logic        r_mem_re;

    // Line parse state
    logic [5:0]  r_len;
    logic [2:0]  r_ntok;
    logic        r_in_tok;
    logic [1:0]  r_cmd_len;
    logic [7:0]  r_cmd0;
    logic [7:0]  r_cmd1;
    logic [31:0] r_arg0;
    logic [31:0] r_arg1;
    logic        r_err;

    // Response state
    logic        r_is_read;
    logic [31:0] r_rd_addr;
    logic [31:0] r_rdata;
    logic [2:0]  r_phase;
    logic        r_ser_sel;
    logic        r_ser_start;
    logic [31:0] r_ser_word;

    logic [7:0]  w_ser_tdata;
    logic        w_ser_tvalid;
    logic        w_ser_done;
    logic [2:0]  w_tidx;
    logic [4:0]  w_hex;
    logic        w_is_sw;
    logic        w_is_lw;

    hex_word_ser u_ser (
        .clk      (clk),
        .rst      (rst),
        .i_start  (r_ser_start),
        .i_word   (r_ser_word),
        .o_tdata  (w_ser_tdata),
        .o_tvalid (w_ser_tvalid),
        .i_tready (io_bus.tx_ready && r_ser_sel),
        .o_done   (w_ser_done)
    );

    // Index of the token the current byte belongs to (a new token if we were between tokens).
    assign w_tidx  = r_in_tok ? (r_ntok - 3'd1) : r_ntok;
    assign w_hex   = hex_to_nib(r_rx_byte);
    assign w_is_sw = (r_cmd_len == 2'd2) && (r_cmd0 == 8'h73) && (r_cmd1 == 8'h77);
    assign w_is_lw = (r_cmd_len == 2'd2) && (r_cmd0 == 8'h6c) && (r_cmd1 == 8'h77);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_PROMPT;
            r_idx       <= 3'd0;
            r_tx_data   <= 8'd0;
            r_tx_valid  <= 1'b0;
            r_rx_byte   <= 8'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_we    <= 4'd0;
            r_mem_re    <= 1'b0;
            r_len       <= 6'd0;
            r_ntok      <= 3'd0;
            r_in_tok    <= 1'b0;
            r_cmd_len   <= 2'd0;
            r_cmd0      <= 8'd0;
            r_cmd1      <= 8'd0;
            r_arg0      <= 32'd0;
            r_arg1      <= 32'd0;
            r_err       <= 1'b0;
            r_is_read   <= 1'b0;
            r_rd_addr   <= 32'd0;
            r_rdata     <= 32'd0;
            r_phase     <= 3'd0;
            r_ser_sel   <= 1'b0;
            r_ser_start <= 1'b0;
            r_ser_word  <= 32'd0;
        end else begin
            r_ser_start <= 1'b0;
            case (r_state)
                ST_PROMPT: begin
                    // Every path back to the prompt starts a fresh line.
                    r_len     <= 6'd0;
                    r_ntok    <= 3'd0;
                    r_in_tok  <= 1'b0;
                    r_cmd_len <= 2'd0;
                    r_arg0    <= 32'd0;
                    r_arg1    <= 32'd0;
                    r_err     <= 1'b0;
                    if (!PROMPT_EN) begin
                        r_state <= ST_RX_WAIT;
                    end else if (!r_tx_valid) begin
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= prompt_byte(r_idx);
                    end else if (io_bus.tx_ready) begin
                        if (r_idx == PROMPT_LAST) begin
                            r_tx_valid <= 1'b0;
                            r_idx      <= 3'd0;
                            r_state    <= ST_RX_WAIT;
                        end else begin
                            r_idx     <= r_idx + 3'd1;
                            r_tx_data <= prompt_byte(r_idx + 3'd1);
                        end
                    end
                end

                ST_RX_WAIT: begin
                    if (io_bus.rx_valid) begin
                        r_rx_byte  <= io_bus.rx_data;
                        r_tx_data  <= io_bus.rx_data;
                        r_tx_valid <= 1'b1;
                        r_state    <= ST_ECHO;
                    end
                end

                ST_ECHO: begin
                    // The byte is only interpreted once its echo has left.
                    if (io_bus.tx_ready) begin
                        r_tx_valid <= 1'b0;
                        if (r_rx_byte == ASCII_CR) begin
                            if (r_len == 6'd0) begin
                                r_state <= ST_PROMPT;
                            end else if (r_err) begin
                                r_state <= ST_ERR;
                            end else if (w_is_sw && r_ntok == 3'd3) begin
                                r_mem_we    <= 4'hF;
                                r_mem_addr  <= {r_arg1[31:2], 2'b00};
                                r_mem_wdata <= r_arg0;
                                r_is_read   <= 1'b0;
                                r_state     <= ST_EXEC_W;
                            end else if (w_is_lw && r_ntok == 3'd2) begin
                                r_mem_re   <= 1'b1;
                                r_mem_addr <= {r_arg0[31:2], 2'b00};
                                r_rd_addr  <= r_arg0;
                                r_is_read  <= 1'b1;
                                r_state    <= ST_EXEC_R;
                            end else begin
                                r_state <= ST_ERR;
                            end
                        end else begin
                            r_state <= ST_RX_WAIT;
                            if (r_len == MAX_LINE_LEN) begin
                                r_err <= 1'b1;
                            end else begin
                                r_len <= r_len + 6'd1;
                            end
                            if (r_rx_byte == ASCII_SP) begin
                                r_in_tok <= 1'b0;
                            end else begin
                                if (!r_in_tok) begin
                                    r_in_tok <= 1'b1;
                                    if (r_ntok != 3'd7) begin
                                        r_ntok <= r_ntok + 3'd1;
                                    end
                                end
                                case (w_tidx)
                                    3'd0: begin
                                        if (r_cmd_len == 2'd0) r_cmd0 <= r_rx_byte;
                                        if (r_cmd_len == 2'd1) r_cmd1 <= r_rx_byte;
                                        if (r_cmd_len != 2'd3) r_cmd_len <= r_cmd_len + 2'd1;
                                    end
                                    3'd1: begin
                                        if (w_hex[4]) r_arg0 <= {r_arg0[27:0], w_hex[3:0]};
                                        else          r_err  <= 1'b1;
                                    end
                                    3'd2: begin
                                        if (w_hex[4]) r_arg1 <= {r_arg1[27:0], w_hex[3:0]};
                                        else          r_err  <= 1'b1;
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    end
                end

                ST_EXEC_W: begin
                    r_mem_we <= 4'd0;
                    r_phase  <= 3'd0;
                    r_state  <= ST_RESP;
                end

                ST_EXEC_R: begin
                    r_mem_re <= 1'b0;
                    r_state  <= ST_READ_WAIT;
                end

                ST_READ_WAIT: begin
                    r_rdata <= io_bus.mem_rdata;
                    r_phase <= 3'd0;
                    r_state <= ST_RESP;
                end

                ST_RESP: begin
                    // Phases: 0 LF, 1 address digits, 2 colon, 3 data digits, 4 CR.
                    case (r_phase)
                        3'd0: begin
                            if (!r_tx_valid) begin
                                r_tx_valid <= 1'b1;
                                r_tx_data  <= ASCII_LF;
                            end else if (io_bus.tx_ready) begin
                                r_tx_valid <= 1'b0;
                                if (r_is_read) begin
                                    r_ser_start <= 1'b1;
                                    r_ser_word  <= r_rd_addr;
                                    r_ser_sel   <= 1'b1;
                                    r_phase     <= 3'd1;
                                end else begin
                                    r_idx   <= 3'd0;
                                    r_state <= ST_PROMPT;
                                end
                            end
                        end
                        3'd1: begin
                            if (w_ser_done) begin
                                r_ser_sel  <= 1'b0;
                                r_tx_valid <= 1'b1;
                                r_tx_data  <= ASCII_COLON;
                                r_phase    <= 3'd2;
                            end
                        end
                        3'd2: begin
                            if (r_tx_valid && io_bus.tx_ready) begin
                                r_tx_valid  <= 1'b0;
                                r_ser_start <= 1'b1;
                                r_ser_word  <= r_rdata;
                                r_ser_sel   <= 1'b1;
                                r_phase     <= 3'd3;
                            end
                        end
                        3'd3: begin
                            if (w_ser_done) begin
                                r_ser_sel  <= 1'b0;
                                r_tx_valid <= 1'b1;
                                r_tx_data  <= ASCII_CR;
                                r_phase    <= 3'd4;
                            end
                        end
                        default: begin
                            if (r_tx_valid && io_bus.tx_ready) begin
                                r_tx_valid <= 1'b0;
                                r_idx      <= 3'd0;
                                r_state    <= ST_PROMPT;
                            end
                        end
                    endcase
                end

                ST_ERR: begin
                    if (!r_tx_valid) begin
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= err_byte(r_idx);
                    end else if (io_bus.tx_ready) begin
                        if (r_idx == ERR_LAST) begin
                            r_tx_valid <= 1'b0;
                            r_idx      <= 3'd0;
                            r_state    <= ST_PROMPT;
                        end else begin
                            r_idx     <= r_idx + 3'd1;
                            r_tx_data <= err_byte(r_idx + 3'd1);
                        end
                    end
                end

                default: r_state <= ST_PROMPT;
            endcase
        end
    end

    // While the serializer owns the line, the FSM's own tx register is idle.
    assign io_bus.tx_data   = r_ser_sel ? w_ser_tdata  : r_tx_data;
    assign io_bus.tx_valid  = r_ser_sel ? w_ser_tvalid : r_tx_valid;
    assign io_bus.rx_ready  = (r_state == ST_RX_WAIT);
    assign io_bus.busy      = (r_state != ST_RX_WAIT);
    assign io_bus.mem_addr  = r_mem_addr;
    assign io_bus.mem_wdata = r_mem_wdata;
    assign io_bus.mem_we    = r_mem_we;
    assign io_bus.mem_re    = r_mem_re;
endmodule

// File: tb/tb_uart_cmd_monitor.sv
// tb/tb_uart_cmd_monitor.sv - directed self-checking bench for uart_cmd_monitor
module tb_uart_cmd_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_cmd_monitor_if bus ();

    uart_cmd_monitor #(.PROMPT_EN(1'b1)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  tx_q[$];
    logic [7:0]  exp_q[$];
    int          we_cnt = 0;
    int          re_cnt = 0;
    int          stab_err = 0;
    logic [31:0] last_waddr = 0;
    logic [31:0] last_wdata = 0;
    logic [31:0] last_raddr = 0;
    logic [3:0]  last_we = 0;
    logic        hold_pend = 0;
    logic [7:0]  hold_data = 0;
    logic [31:0] mem_word = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Memory model: one word, written by sw, returned by lw one cycle after mem_re.
    always @(posedge clk) begin
        if (bus.mem_we == 4'hF) mem_word <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem_word;
    end

    // Observation at the falling edge; inputs change 2 time units after the rising edge.
    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend && (!bus.tx_valid || bus.tx_data != hold_data)) stab_err++;
            hold_pend = bus.tx_valid && !bus.tx_ready;
            hold_data = bus.tx_data;
            if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
            if (bus.mem_we != 4'd0) begin
                we_cnt++;
                last_we    = bus.mem_we;
                last_waddr = bus.mem_addr;
                last_wdata = bus.mem_wdata;
            end
            if (bus.mem_re) begin
                re_cnt++;
                last_raddr = bus.mem_addr;
            end
        end
    end

    task automatic clear_log();
        tx_q.delete();
        exp_q.delete();
        we_cnt   = 0;
        re_cnt   = 0;
        stab_err = 0;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic push_prompt();
        exp_q.push_back(8'h0d); exp_q.push_back(8'h0a); exp_q.push_back(8'h31);
        exp_q.push_back(8'h35); exp_q.push_back(8'h31); exp_q.push_back(8'h3e);
        exp_q.push_back(8'h20);
    endtask

    task automatic push_err();
        exp_q.push_back(8'h0a); exp_q.push_back(8'h45); exp_q.push_back(8'h52);
        exp_q.push_back(8'h52); exp_q.push_back(8'h0d);
    endtask

    task automatic compare_stream(input string tag);
        int nf;
        nf = n_checks - n_pass;
        check_eq({tag, "_len"}, tx_q.size(), exp_q.size());
        for (int i = 0; i < tx_q.size() && i < exp_q.size(); i++) begin
            check_eq($sformatf("%s_byte%0d", tag, i), tx_q[i], exp_q[i]);
            if (n_checks - n_pass != nf) break;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_tx_valid"},  bus.tx_valid,  0);
        check_eq({tag, "_rx_ready"},  bus.rx_ready,  0);
        check_eq({tag, "_mem_we"},    bus.mem_we,    0);
        check_eq({tag, "_mem_re"},    bus.mem_re,    0);
        check_eq({tag, "_mem_addr"},  bus.mem_addr,  0);
        check_eq({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check_eq({tag, "_busy"},      bus.busy,      1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #2;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (bus.rx_ready) ok = 1'b1;
        end
        @(posedge clk); #2;
        bus.rx_valid = 1'b0;
        if (!ok) check_eq("rx_accept_timeout", ok, 1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            if (bus.rx_ready) ok = 1'b1;
        end
        if (!ok) check_eq({tag, "_timeout"}, ok, 1);
        @(posedge clk); #2;
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        send_byte(8'h0d);
    endtask

    task automatic expect_read(input string line, input string resp);
        push_str(line); exp_q.push_back(8'h0d); exp_q.push_back(8'h0a);
        push_str(resp); exp_q.push_back(8'h0d); push_prompt();
    endtask

    task automatic expect_err(input string line);
        push_str(line); exp_q.push_back(8'h0d); push_err(); push_prompt();
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog expired n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        string s32, s33;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        bus.tx_ready = 1'b1;
        s32 = {"lw ", "0000000000", "0000000000", "00", "1234567"};
        s33 = {"lw ", "0000000000", "0000000000", "000", "1234567"};

        // Reset values and prompt after release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk); #2;
        rst = 1'b0;
        clear_log();
        @(negedge clk);
        check_eq("first_cycle_tx_valid", bus.tx_valid, 0);
        @(negedge clk);
        check_eq("first_byte_valid", bus.tx_valid, 1);
        check_eq("first_byte_data", bus.tx_data, 8'h0d);
        wait_idle("prompt");
        check_eq("prompt_count_at_rx_ready", tx_q.size(), 7);
        check_eq("idle_busy", bus.busy, 0);
        push_prompt();
        compare_stream("prompt");

        // Word write
        clear_log();
        send_line("sw cafeaaaa 30000004");
        wait_idle("sw");
        push_str("sw cafeaaaa 30000004"); exp_q.push_back(8'h0d); exp_q.push_back(8'h0a); push_prompt();
        compare_stream("sw");
        check_eq("sw_we_cycles", we_cnt, 1);
        check_eq("sw_we", last_we, 4'hF);
        check_eq("sw_addr", last_waddr, 32'h30000004);
        check_eq("sw_wdata", last_wdata, 32'hcafeaaaa);
        check_eq("sw_re", re_cnt, 0);

        // Word read
        clear_log();
        send_line("lw 30000004");
        wait_idle("lw");
        expect_read("lw 30000004", "30000004:cafeaaaa");
        compare_stream("lw");
        check_eq("lw_re_pulses", re_cnt, 1);
        check_eq("lw_addr", last_raddr, 32'h30000004);
        check_eq("lw_we", we_cnt, 0);

        // Error lines
        clear_log();
        send_line("abcd");
        wait_idle("err_cmd");
        expect_err("abcd");
        compare_stream("err_cmd");
        check_eq("err_cmd_mem", we_cnt + re_cnt, 0);

        clear_log();
        send_line("lw 3000zz04");
        wait_idle("err_hex");
        expect_err("lw 3000zz04");
        compare_stream("err_hex");
        check_eq("err_hex_mem", we_cnt + re_cnt, 0);

        clear_log();
        send_line("sw 12");
        wait_idle("err_argc");
        expect_err("sw 12");
        compare_stream("err_argc");
        check_eq("err_argc_mem", we_cnt + re_cnt, 0);

        // Empty line
        clear_log();
        send_byte(8'h0d);
        wait_idle("empty");
        exp_q.push_back(8'h0d); push_prompt();
        compare_stream("empty");
        check_eq("empty_mem", we_cnt + re_cnt, 0);

        // Uppercase digits, more than 8 digits, unaligned address printed unmodified
        clear_log();
        send_line("lw 1ABCDEF07");
        wait_idle("lw_long_arg");
        expect_read("lw 1ABCDEF07", "abcdef07:cafeaaaa");
        compare_stream("lw_long_arg");
        check_eq("lw_long_arg_addr", last_raddr, 32'habcdef04);

        // 32-byte line accepted, 33-byte line rejected
        clear_log();
        send_line(s32);
        wait_idle("len32");
        expect_read(s32, "01234567:cafeaaaa");
        compare_stream("len32");
        check_eq("len32_addr", last_raddr, 32'h01234564);

        clear_log();
        send_line(s33);
        wait_idle("len33");
        expect_err(s33);
        compare_stream("len33");
        check_eq("len33_mem", we_cnt + re_cnt, 0);

        // Read response with tx back-pressure
        clear_log();
        send_line("lw 30000004");
        fork
            wait_idle("stall");
            begin
                repeat (3) @(posedge clk); #2 bus.tx_ready = 1'b0;
                repeat (5) @(posedge clk); #2 bus.tx_ready = 1'b1;
                repeat (4) @(posedge clk); #2 bus.tx_ready = 1'b0;
                repeat (5) @(posedge clk); #2 bus.tx_ready = 1'b1;
                repeat (6) @(posedge clk); #2 bus.tx_ready = 1'b0;
                repeat (5) @(posedge clk); #2 bus.tx_ready = 1'b1;
            end
        join
        expect_read("lw 30000004", "30000004:cafeaaaa");
        compare_stream("stall");
        check_eq("stall_stable", stab_err, 0);
        check_eq("stall_re_pulses", re_cnt, 1);

        // Multiple separating spaces, aligned-down address
        clear_log();
        send_line("sw  0000beef   00000013");
        wait_idle("sw_spaces");
        push_str("sw  0000beef   00000013"); exp_q.push_back(8'h0d); exp_q.push_back(8'h0a); push_prompt();
        compare_stream("sw_spaces");
        check_eq("sw_spaces_addr", last_waddr, 32'h00000010);
        check_eq("sw_spaces_wdata", last_wdata, 32'h0000beef);

        // Reset during the data digits of a read response
        clear_log();
        send_line("lw 30000004");
        for (int i = 0; i < 4000 && tx_q.size() < 25; i++) @(posedge clk);
        check_eq("midrst_reached", tx_q.size() >= 25, 1);
        #2 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("midrst");
        @(posedge clk); #2;
        rst = 1'b0;
        clear_log();
        wait_idle("midrst_prompt");
        push_prompt();
        compare_stream("midrst_prompt");
        check_eq("midrst_mem", we_cnt + re_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
